// File: rtl/load_store_unit.sv
// Data-memory access stage: drives one req/gnt/rvalid bus transaction per load/store, returns extended load data.
// Latency: store 2 cycles, load 3 cycles minimum; non-access and misaligned instructions add none.
// Backpressure: holds stall high until the transaction finishes or the TIMEOUT abort fires; no overlapping transactions.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mask_type,
    input  logic        ext_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    // Counter only needs to reach TIMEOUT-3; the IDLE cycle is the first bus cycle.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 3);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic            access, is_write, is_byte, is_half, is_word;
    logic            misal, go, last_cyc, abort;
    logic            req_c, stall_c;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c, load_ext;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign access   = mem_read | mem_write;
    assign is_write = mem_write;              // write wins when both are set
    assign is_byte  = (mask_type == 2'b00);
    assign is_half  = (mask_type == 2'b01);
    assign is_word  = mask_type[1];           // 11 behaves as word
    assign misal    = access & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
    assign go       = access & ~misal;

    // Final allowed bus cycle of this access: abort if it does not complete here.
    assign last_cyc = (state_q == IDLE) ? (TIMEOUT == 2) : (cnt_q == LAST_CNT);

    // Store lane placement: byte enables and replicated write data.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        if (is_byte) begin
            be_c    = 4'b0001 << addr[1:0];
            wdata_c = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_c    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata[15:0]}};
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        byte_sel = bus_rdata[8*addr[1:0] +: 8];
        half_sel = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext = bus_rdata;
        if (is_byte) begin
            load_ext = ext_type ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            load_ext = ext_type ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
    end

    // Next-state, request and stall decode.
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE, REQ: begin
                if (state_q == REQ || go) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (bus_gnt && is_write) begin
                        state_d = DONE;
                    end else if (last_cyc) begin
                        state_d = DONE;
                        abort   = 1'b1;
                    end else if (bus_gnt) begin
                        state_d = WAIT_R;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            WAIT_R: begin
                stall_c = 1'b1;
                if (bus_rvalid) begin
                    state_d = DONE;
                end else if (last_cyc) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, timeout counter, abort flag and captured load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == REQ || state_q == WAIT_R) ? cnt_q + CW'(1) : '0;
            err_q   <= abort;
            rdata_q <= (state_q == WAIT_R && bus_rvalid) ? load_ext : 32'd0;
        end
    end

    // Every output is forced low while reset is held, even with an access present.
    assign stall      = rst_n & stall_c;
    assign bus_req    = rst_n & req_c;
    assign misaligned = rst_n & misal;
    assign bus_err    = rst_n & (state_q == DONE) & err_q;
    assign rdata      = (rst_n && state_q == DONE) ? rdata_q : 32'd0;
    assign bus_we     = bus_req & is_write;
    assign bus_addr   = bus_req ? {addr[31:2], 2'b00} : 32'd0;
    assign bus_be     = bus_req ? be_c : 4'd0;
    assign bus_wdata  = bus_req ? wdata_c : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level reference model.
// Each access is resolved in closed form (completion cycle, abort, lane data) and compared cycle by cycle.
// The bench plays the bus: one gnt pulse, one rvalid pulse, plus optional rvalid noise the DUT must ignore.
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, ext_type;
    logic [1:0]  mask_type;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mask_type(mask_type), .ext_type(ext_type),
        .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] mt);
        return (mt == 2'b00) ? 1 : (mt == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] mt,
                                             input logic [31:0] a, input logic ext);
        int n = nbytes(mt);
        int off = int'(a % 4);
        logic [31:0] v;
        if (n == 4) return word;
        v = (word >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
        if (!ext && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [1:0] mt, input logic [31:0] a);
        int n = nbytes(mt);
        return ((32'd1 << n) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] mt, input logic [31:0] wd);
        int n = nbytes(mt);
        if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    // One instruction: g = cycle index of gnt, r = extra wait cycles before rvalid.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] mt, input logic ext,
                              input logic [31:0] a, input logic [31:0] wd, input int g, input int r,
                              input logic [31:0] word, input bit noise);
        bit acc = rd | wr;
        bit mis = acc && ((a % nbytes(mt)) != 0);
        int comp, done, rv_cyc;
        bit ok;
        logic [31:0] exp_rd;
        if (!acc || mis) begin
            @(posedge clk); #1;
            mem_read = rd; mem_write = wr; mask_type = mt; ext_type = ext; addr = a; wdata = wd;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            #1;
            check_eq("misaligned", misaligned, mis);
            check_eq("noacc_stall", stall, 0);
            check_eq("noacc_req", bus_req, 0);
            check_eq("noacc_rdata", rdata, 0);
            return;
        end
        rv_cyc = g + 1 + r;
        comp   = wr ? g : rv_cyc;
        ok     = comp <= TMO - 2;
        done   = ok ? comp + 1 : TMO - 1;
        exp_rd = (!wr && ok) ? ref_load(word, mt, a, ext) : 32'd0;
        for (int c = 0; c <= done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                mem_read = rd; mem_write = wr; mask_type = mt; ext_type = ext; addr = a; wdata = wd;
            end
            bus_gnt    = (c == g);
            bus_rvalid = (!wr && c == rv_cyc) || (noise && c <= g && $urandom_range(0, 1) == 1);
            bus_rdata  = (c == rv_cyc) ? word : $urandom;
            #1;
            check_eq("stall", stall, c < done);
            check_eq("bus_req", bus_req, (c <= g) && (c < done));
            if (c <= g && c < done) begin
                check_eq("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                check_eq("bus_be", bus_be, ref_be(mt, a));
                check_eq("bus_we", bus_we, wr);
                if (wr) check_eq("bus_wdata", bus_wdata, ref_wd(mt, wd));
            end
            if (c == done) begin
                check_eq("rdata", rdata, exp_rd);
                check_eq("bus_err", bus_err, !ok);
            end else begin
                check_eq("rdata_idle", rdata, 0);
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mask_type = 2'b10; ext_type = 1'b0;
        addr = 32'h100; wdata = 32'h0; bus_gnt = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #2;
        check_eq("rst_req", bus_req, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_be", bus_be, 0);
        check_eq("rst_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; mem_read = 1'b0; bus_gnt = 1'b0;

        // Directed cases
        run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
        run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 0);
        run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 0);
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 3, 0, 32'h0, 0);
        run_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0);
        run_access(1, 1, 2'b00, 0, 32'h0F1, 32'hA5A5_5A77, 1, 0, 32'h0, 0);
        run_access(0, 1, 2'b10, 0, 32'h400, 32'h1111_2222, 100, 0, 32'h0, 0);
        run_access(1, 0, 2'b01, 0, 32'h402, 32'h0, 100, 0, 32'h0, 0);
        run_access(1, 0, 2'b01, 0, 32'h406, 32'h0, 2, 9, 32'h8765_4321, 0);
        run_access(0, 0, 2'b10, 0, 32'h123, 32'h0, 0, 0, 32'h0, 0);

        // Reset while waiting for read data
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; mask_type = 2'b10; addr = 32'h40; bus_gnt = 1'b1;
        #1; check_eq("mr_req", bus_req, 1);
        @(posedge clk); #1; bus_gnt = 1'b0;
        #1; check_eq("mr_wait_stall", stall, 1);
        rst_n = 1'b0;
        #1; check_eq("mr_rst_stall", stall, 0);
        check_eq("mr_rst_req", bus_req, 0);
        @(posedge clk); #1; mem_read = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1; check_eq("mr_late_stall", stall, 0);
        check_eq("mr_late_rdata", rdata, 0);
        @(posedge clk); #1; bus_rvalid = 1'b0;
        #1; check_eq("mr_late_rdata2", rdata, 0);
        run_access(1, 0, 2'b10, 0, 32'h44, 32'h0, 1, 1, 32'h0BAD_CAFE, 0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic rd, wr, ext;
            logic [1:0] mt;
            logic [31:0] a;
            int g, r;
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            ext = 1'($urandom_range(0, 1));
            mt  = 2'($urandom_range(0, 3));
            a   = $urandom;
            g   = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            r   = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 2);
            run_access(rd, wr, mt, ext, a, $urandom, g, r, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the single-cycle core. Consumes the decoded memory controls (MemWrite, ResultSrc-derived read strobe, mask_type, ext_type), the ALU result as address and rs2 as store data. Runs a req/gnt/rvalid bus transaction, stalling the core until the transaction completes. Returns the lane-selected, extended load value to the write-back mux.

## Interface
- TIMEOUT, default 64: bus cycles allowed per access (REQ+WAIT_R) before abort with bus_err; ≥2.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  load instruction (ResultSrc == 2'b01).
- mem_write  in  1  store instruction (MemWrite).
- mask_type  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ext_type  in  1  0 sign-extend, 1 zero-extend (loads only).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result, valid while stall=0 in DONE.
- stall  out  1  core must hold PC and all inputs stable.
- misaligned  out  1  access not naturally aligned; no bus traffic.
- bus_err  out  1  timeout abort, asserted in DONE cycle only.
- bus_req  out  1  address-phase request.
- bus_we  out  1  1 write, 0 read.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  address phase accepted this cycle.
- bus_rvalid  in  1  read data valid this cycle.
- bus_rdata  in  32  read word.

## Operation
- access = mem_read | mem_write; both high: write wins, no read performed.
- misaligned = access & ((half & addr[0]) | (word & addr[1:0]≠0)); combinational, stall=0, bus_req=0, rdata=0, FSM stays IDLE.
- FSM states IDLE, REQ, WAIT_R, DONE:
  - IDLE: aligned access → bus_req=1, stall=1 combinationally. gnt same cycle: write→DONE, read→WAIT_R; else →REQ.
  - REQ: bus_req=1, stall=1, request fields held. gnt: write→DONE, read→WAIT_R.
  - WAIT_R: bus_req=0, stall=1. rvalid: capture extended data into rdata register →DONE. rvalid ignored in all other states.
  - DONE: stall=0, bus_req=0, core commits; →IDLE unconditionally (same instruction not re-issued).
- Timeout counter: cleared in IDLE, increments each cycle in REQ/WAIT_R. Reaching TIMEOUT-1 without completion →DONE, rdata=0, bus_err=1 for the DONE cycle; store is considered lost.
- Store lanes: byte: be=4'b0001<<addr[1:0], wdata[7:0] replicated ×4. Half: be=addr[1]?1100:0011, wdata[15:0] replicated ×2. Word: be=1111, wdata as is. Reads drive be as for stores (bus may ignore).
- Load extract: byte lane addr[1:0], half lane addr[1]; extend to 32 bits per ext_type; word passes through.
- rdata is 0 outside DONE and for stores.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0, rdata register 0; all outputs 0 while asserted (bus_req forced 0 even with access present). Reset mid-transaction drops bus_req immediately; outstanding rvalid after release is ignored.
- Store, gnt in first cycle: 1 stall cycle + DONE = 2 cycles per instruction.
- Load, gnt first cycle, rvalid next: 2 stall cycles + DONE = 3 cycles.
- rvalid never earlier than cycle after gnt; same-cycle gnt/rvalid in REQ treated as gnt only.
- Non-access instructions: stall=0, zero added latency.
- Back-to-back accesses: each passes IDLE once; no overlap of bus transactions.

## Test plan
- LW addr=0x100, gnt cycle0, rvalid cycle1 bus_rdata=0xDEADBEEF → stall 1,1,0; rdata=0xDEADBEEF in cycle2; bus_addr=0x100, be=1111.
- LB addr=0x103, bus_rdata=0x80xxxxxx, ext_type=0 → rdata=0xFFFFFF80; ext_type=1 (LBU) → 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, gnt after 3 wait cycles → bus_be=1100, bus_wdata=0xABCDABCD held 4 cycles, stall drops in DONE.
- LW addr=0x101 → misaligned=1, stall=0, no bus_req, rdata=0.
- TIMEOUT=8, gnt never asserted → bus_req high 7 cycles, DONE with bus_err=1, rdata=0, next cycle IDLE.
- rst_n low while in WAIT_R → bus_req/stall 0 immediately; late rvalid after release ignored; next load completes normally.
